// File: rtl/exp_1x1_pkg.sv
// Shared definitions for the expand-1x1 kernel write path: FSM encoding and
// counter widths used by exp_1x1_ker_wr_ctrl and exp_1x1_wr_addr_cnt.
package exp_1x1_pkg;

   localparam int EXP1_ADDR_W = 12;
   localparam int EXP1_LAYR_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } exp1_state_e;

endpackage

// File: rtl/exp_1x1_wr_addr_cnt.sv
// Address / slice / layer counters for the expand-1x1 kernel write sequencer.
// Limits are captured on clr; slice_tc and fire_tc flag the terminal beat.
module exp_1x1_wr_addr_cnt
   import exp_1x1_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr,
   input  logic                   adv,
   input  logic [EXP1_ADDR_W-1:0] fire_lim,
   input  logic [EXP1_LAYR_W-1:0] layr_lim,
   output logic [EXP1_ADDR_W-1:0] addr,
   output logic [EXP1_ADDR_W-1:0] layr_cnt,
   output logic                   slice_tc,
   output logic                   fire_tc
);

   logic [EXP1_ADDR_W-1:0] addr_r;
   logic [EXP1_LAYR_W-1:0] word_cnt_r;
   logic [EXP1_ADDR_W-1:0] layr_cnt_r;
   logic [EXP1_ADDR_W-1:0] fire_lim_r;
   logic [EXP1_LAYR_W-1:0] layr_lim_r;

   assign addr     = addr_r;
   assign layr_cnt = layr_cnt_r;
   assign slice_tc = (word_cnt_r == layr_lim_r);
   assign fire_tc  = (addr_r == fire_lim_r);

   // Counter state: cleared and limits captured on clr, stepped on each accepted beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_r     <= '0;
         word_cnt_r <= '0;
         layr_cnt_r <= '0;
         fire_lim_r <= '0;
         layr_lim_r <= '0;
      end else if (clr) begin
         addr_r     <= '0;
         word_cnt_r <= '0;
         layr_cnt_r <= '0;
         fire_lim_r <= fire_lim;
         layr_lim_r <= layr_lim;
      end else if (adv) begin
         addr_r <= addr_r + EXP1_ADDR_W'(1);
         if (slice_tc) begin
            word_cnt_r <= '0;
            layr_cnt_r <= layr_cnt_r + EXP1_ADDR_W'(1);
         end else begin
            word_cnt_r <= word_cnt_r + EXP1_LAYR_W'(1);
            layr_cnt_r <= layr_cnt_r;
         end
      end else begin
         addr_r     <= addr_r;
         word_cnt_r <= word_cnt_r;
         layr_cnt_r <= layr_cnt_r;
      end
   end

endmodule

// File: rtl/exp_1x1_ker_wr_ctrl.sv
// Expand-1x1 kernel RAM write sequencer: streams loader words into linear RAM
// addresses and flags slice/fire completion. Optional EXP1_WR_ERR_CHK_EN adds a sticky protocol error flag.
module exp_1x1_ker_wr_ctrl
   import exp_1x1_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   exp_1x1_en_i,
   input  logic [EXP1_ADDR_W-1:0] tot_exp1_ker_addr_limit_i,
   input  logic [EXP1_LAYR_W-1:0] one_exp1_ker_addr_limit_i,
   input  logic [DATA_W-1:0]      ker_data_i,
   input  logic                   ker_valid_i,
   output logic                   ker_ready_o,
   output logic                   ker_wr_en_o,
   output logic [EXP1_ADDR_W-1:0] ker_wr_addr_o,
   output logic [DATA_W-1:0]      ker_wr_data_o,
   output logic [EXP1_ADDR_W-1:0] layr_cnt_o,
   output logic                   layr_done_o,
   output logic                   fire_done_o,
   output logic                   busy_o,
   output logic                   err_o
);

   exp1_state_e            state_r;
   logic                   beat_s;
   logic                   load_start_s;
   logic [EXP1_LAYR_W-1:0] layr_lim_s;
   logic [EXP1_ADDR_W-1:0] cnt_addr_s;
   logic                   slice_tc_s;
   logic                   fire_tc_s;

   // ker_ready_o is only high in LOAD, so it alone qualifies the handshake.
   assign beat_s       = ker_valid_i & ker_ready_o;
   assign load_start_s = start_i & exp_1x1_en_i & (state_r == ST_IDLE);
   // 7-bit wrap: a slice size of 0 means 128 words.
   assign layr_lim_s   = one_exp1_ker_addr_limit_i - EXP1_LAYR_W'(1);

   exp_1x1_wr_addr_cnt u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr      (load_start_s),
      .adv      (beat_s),
      .fire_lim (tot_exp1_ker_addr_limit_i),
      .layr_lim (layr_lim_s),
      .addr     (cnt_addr_s),
      .layr_cnt (layr_cnt_o),
      .slice_tc (slice_tc_s),
      .fire_tc  (fire_tc_s)
   );

   // Sequencer FSM with all handshake, write and status outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r       <= ST_IDLE;
         ker_ready_o   <= 1'b0;
         ker_wr_en_o   <= 1'b0;
         ker_wr_addr_o <= '0;
         ker_wr_data_o <= '0;
         layr_done_o   <= 1'b0;
         fire_done_o   <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         ker_wr_en_o <= 1'b0;
         layr_done_o <= 1'b0;
         fire_done_o <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_i && exp_1x1_en_i) begin
                  state_r     <= ST_LOAD;
                  ker_ready_o <= 1'b1;
                  busy_o      <= 1'b1;
               end else if (start_i) begin
                  // Path unused this layer: report completion without loading.
                  fire_done_o <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (beat_s) begin
                  ker_wr_en_o   <= 1'b1;
                  ker_wr_addr_o <= cnt_addr_s;
                  ker_wr_data_o <= ker_data_i;
                  layr_done_o   <= slice_tc_s;
                  if (fire_tc_s) begin
                     state_r     <= ST_DONE;
                     ker_ready_o <= 1'b0;
                     fire_done_o <= 1'b1;
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               ker_ready_o <= 1'b0;
               busy_o      <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               ker_ready_o <= 1'b0;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

`ifdef EXP1_WR_ERR_CHK_EN
   logic err_r;
   logic err_evt_s;

   assign err_evt_s = (ker_valid_i && (state_r == ST_IDLE || state_r == ST_DONE)) ||
                      (start_i && (state_r == ST_LOAD));
   assign err_o     = err_r;

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_r <= 1'b0;
      end else if (err_evt_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: doc/exp_1x1_ker_wr_ctrl.md
# exp_1x1_ker_wr_ctrl

Write sequencer for the expand-1x1 kernel buffer. On `start_i` it latches the fire-layer kernel geometry, accepts kernel weight words from the loader over a valid/ready stream, and writes them to linear kernel-RAM addresses. It flags each completed depth slice and the completed fire layer. It sits between the weight loader and the expand-1x1 kernel RAM, in parallel with the expand-1x1 configuration register block.

## Interface
Parameters:
- `DATA_W`, 64, width of one kernel word (4 packed kernels)

Ports (reset is synchronous, active-high):
- `clk_i` in 1: system clock
- `rst_i` in 1: synchronous active-high reset
- `start_i` in 1: fire-layer start pulse
- `exp_1x1_en_i` in 1: the expand-1x1 path is used this fire layer
- `tot_exp1_ker_addr_limit_i` in 12: total words minus 1
- `one_exp1_ker_addr_limit_i` in 7: words per depth slice
- `ker_data_i` in DATA_W: kernel word
- `ker_valid_i` in 1: kernel word valid
- `ker_ready_o` out 1: block accepts a word
- `ker_wr_en_o` out 1: RAM write strobe
- `ker_wr_addr_o` out 12: RAM write address
- `ker_wr_data_o` out DATA_W: RAM write data
- `layr_cnt_o` out 12: number of depth slices completed
- `layr_done_o` out 1: one-cycle pulse, a depth slice is complete
- `fire_done_o` out 1: one-cycle pulse, the kernel load is complete
- `busy_o` out 1: state is not IDLE
- `err_o` out 1: sticky protocol error (only with `EXP1_WR_ERR_CHK_EN`)

## Operation
- FSM states: IDLE, LOAD, DONE.
- **IDLE**
  - On `start_i & exp_1x1_en_i`: latch `fire_lim = tot_exp1_ker_addr_limit_i` and `layr_lim = one_exp1_ker_addr_limit_i - 1` (7-bit wrap, so 0 means 128 words per slice). Clear `addr`, `word_cnt` and `layr_cnt_o`. Go to LOAD.
  - On `start_i & ~exp_1x1_en_i`: no words are accepted. `fire_done_o` pulses next cycle. Stay in IDLE.
- **LOAD**
  - `ker_ready_o = 1`. A beat is accepted when `ker_valid_i & ker_ready_o`.
  - Each accepted beat is written at `addr`, then `addr` increments.
  - When the beat is accepted with `word_cnt == layr_lim`: `word_cnt` returns to 0, `layr_cnt_o` increments, and `layr_done_o` pulses.
  - When the beat is accepted with `addr == fire_lim`: go to DONE. `ker_ready_o` drops the next cycle.
- **DONE**: one cycle. `fire_done_o = 1`. Go to IDLE.
- `start_i` in LOAD or DONE is ignored.
- `fire_lim` of 0 means a single-word load.
- Arithmetic: `addr` is 12-bit and never wraps, because LOAD exits at `fire_lim`. `word_cnt` is 7-bit. `layr_cnt_o` is 12-bit.
- A final beat that is also a slice end produces `layr_done_o` and `fire_done_o` in the same cycle.

## Timing
- Reset values: `ker_ready_o`, `ker_wr_en_o`, `layr_done_o`, `fire_done_o`, `busy_o` and `err_o` are 0. `ker_wr_addr_o`, `ker_wr_data_o` and `layr_cnt_o` are 0. State is IDLE.
- `start_i` at cycle N gives `ker_ready_o = 1` and `busy_o = 1` at N+1.
- A beat accepted at cycle N gives `ker_wr_en_o`, `ker_wr_addr_o` and `ker_wr_data_o` registered at N+1. `layr_done_o` and `layr_cnt_o` also update at N+1.
- The final beat accepted at N gives `fire_done_o` at N+1 (state DONE) and IDLE at N+2.
- `ker_ready_o` is a registered state decode. It does not depend combinationally on `ker_valid_i`.
- Reset mid-LOAD has priority over everything: all outputs return to reset values on the next edge, and no further write is issued.

## Configuration
- `EXP1_WR_ERR_CHK_EN` defined:
  - `err_o` sets when `ker_valid_i` is high while state is IDLE or DONE, or when `start_i` arrives during LOAD.
  - `err_o` clears only on reset.
- `EXP1_WR_ERR_CHK_EN` undefined: `err_o` is tied to 0 and no checker logic exists.

## Structure
- Shared package `exp_1x1_pkg` holds:
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - `EXP1_ADDR_W = 12`, `EXP1_LAYR_W = 7`.
- Natural sub-module: `exp_1x1_wr_addr_cnt`. It holds the `addr`/`word_cnt`/`layr_cnt` counters with slice and fire terminal-count flags. The FSM and output registers stay in the top.

## Test plan
- tot=7, one=4, en=1, `ker_valid_i` always high → 8 writes at addr 0..7 on consecutive cycles; `layr_done_o` after addr 3 and after addr 7; `fire_done_o` coincides with the addr-7 `layr_done_o`; `layr_cnt_o` = 2.
- Same config with `ker_valid_i` toggling every cycle → addresses remain contiguous 0..7, with writes only on accepted beats.
- start with en=0 → `ker_ready_o` stays 0, no writes, `fire_done_o` pulses 1 cycle after start.
- tot=0, one=1 → a single write at addr 0; `layr_done_o` and `fire_done_o` pulse together.
- `rst_i` asserted after the 3rd beat → next cycle all outputs are 0 and IDLE; a new start with tot=3 writes addr 0..3.
- `EXP1_WR_ERR_CHK_EN` build, `ker_valid_i` high in IDLE → `err_o` = 1 next cycle and stays 1 until `rst_i`.
